xbus_pkt_gen: RTL and testbench

- Upstream packet source for the X-bus filter chain.
- On `start`, sweeps the input feature map stored in the X buffer RAM in row / column-group / channel-group order.
- For each word it emits one tagged `Q*S*8`-bit packet on `pkt_tag`/`pkt_data`, the head of the filter chain.
- Throttles on the OR of all per-filter `cache_full` flags and signals completion with a `done` pulse.

---
 rtl/xbus_pkt_gen_pkg.sv | 59 +++++
 rtl/xbus_pkt_gen_if.sv | 34 +++
 rtl/xbus_pkt_gen_cnt.sv | 50 +++++
 rtl/xbus_pkt_gen.sv | 187 ++++++++++++++++++
 tb/tb_xbus_pkt_gen.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xbus_pkt_gen_pkg.sv
// xbus_pkt_gen shared definitions: packet geometry, tag layout, FSM states.
// Imported by the counter, the bus interface and the top level.
package xbus_pkt_gen_pkg;

    // Packet payload geometry and filter count.
    localparam int Q = 2;
    localparam int S = 2;
    localparam int P = 4;
    localparam int DATA_W = Q * S * 8;

    // Width of each of the three sweep counters.
    localparam int CNT_W = 16;

    // Tag layout {valid, last, row, colgrp, chgrp}, LSB first offsets.
    localparam int TAG_CHGRP_W  = CNT_W;
    localparam int TAG_COLGRP_W = CNT_W;
    localparam int TAG_ROW_W    = CNT_W;
    localparam int TAG_CHGRP    = 0;
    localparam int TAG_COLGRP   = TAG_CHGRP + TAG_CHGRP_W;
    localparam int TAG_ROW      = TAG_COLGRP + TAG_COLGRP_W;
    localparam int TAG_LAST     = TAG_ROW + TAG_ROW_W;
    localparam int TAG_VALID    = TAG_LAST + 1;
    localparam int XBUS_TAG_WIDTH = TAG_VALID + 1;

    // Reads in flight never exceed RD_LAT+1, so 3 bits cover RD_LAT<=4.
    localparam int INFL_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

    // Packed so that the bit layout matches the TAG_* offsets above.
    typedef struct packed {
        logic                    valid;
        logic                    last;
        logic [TAG_ROW_W-1:0]    row;
        logic [TAG_COLGRP_W-1:0] colgrp;
        logic [TAG_CHGRP_W-1:0]  chgrp;
    } tag_t;

    // Builds the tag of a word that is being issued this cycle.
    function automatic tag_t make_tag(
        input logic             last,
        input logic [CNT_W-1:0] row,
        input logic [CNT_W-1:0] colgrp,
        input logic [CNT_W-1:0] chgrp
    );
        tag_t t;
        t.valid  = 1'b1;
        t.last   = last;
        t.row    = row;
        t.colgrp = colgrp;
        t.chgrp  = chgrp;
        return t;
    endfunction

endpackage

// File: rtl/xbus_pkt_gen_if.sv
// X-bus side of the packet generator: X buffer read port, packet output
// towards the filter chain and the per-filter cache-full flags.
interface xbus_pkt_gen_if #(
    parameter int ADDR_W = 16
);

    logic                                xbuf_rd_en;
    logic [ADDR_W-1:0]                   xbuf_rd_addr;
    logic [xbus_pkt_gen_pkg::DATA_W-1:0] xbuf_rd_data;
    logic [xbus_pkt_gen_pkg::XBUS_TAG_WIDTH-1:0] pkt_tag;
    logic [xbus_pkt_gen_pkg::DATA_W-1:0] pkt_data;
    logic [xbus_pkt_gen_pkg::P-1:0]      cache_full;

    // The packet generator drives reads and packets.
    modport master (
        output xbuf_rd_en,
        output xbuf_rd_addr,
        input  xbuf_rd_data,
        output pkt_tag,
        output pkt_data,
        input  cache_full
    );

    // RAM and filter chain side.
    modport slave (
        input  xbuf_rd_en,
        input  xbuf_rd_addr,
        output xbuf_rd_data,
        input  pkt_tag,
        input  pkt_data,
        output cache_full
    );

endinterface

// File: rtl/xbus_pkt_gen_cnt.sv
// Three-level sweep counter: chgrp innermost, colgrp middle, row outermost.
// Limits are inclusive maxima; last_word flags the final position.
module xbus_pkt_gen_cnt
    import xbus_pkt_gen_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [CNT_W-1:0] ch_max,
    input  logic [CNT_W-1:0] col_max,
    input  logic [CNT_W-1:0] row_max,
    output logic [CNT_W-1:0] ch,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             last_word
);

    logic ch_wrap;
    logic col_wrap;

    // Carry chain: a level wraps only when all inner levels wrap.
    always_comb begin
        ch_wrap   = (ch == ch_max);
        col_wrap  = ch_wrap && (col == col_max);
        last_word = col_wrap && (row == row_max);
    end

    // Advance the nested counters by one word per issued read.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ch  <= '0;
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (!ch_wrap) begin
                ch <= ch + CNT_W'(1);
            end else begin
                ch <= '0;
                if (!col_wrap) begin
                    col <= col + CNT_W'(1);
                end else begin
                    col <= '0;
                    row <= row + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/xbus_pkt_gen.sv
// X-bus packet source: sweeps the X buffer map and emits one tagged packet
// per word, throttled by the filters' cache-full flags.
module xbus_pkt_gen
    import xbus_pkt_gen_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       INC2_minus_1,
    input  logic [15:0]       INW_,
    input  logic [15:0]       INH2,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    xbus_pkt_gen_if.master    bus
);

    state_e state;
    state_e state_n;

    logic [CNT_W-1:0]  ch_max_r;
    logic [CNT_W-1:0]  col_max_r;
    logic [CNT_W-1:0]  row_max_r;
    logic [ADDR_W-1:0] addr_r;

    logic full_r;
    logic accept;
    logic issue;
    logic done_n;
    logic done_r;
    logic pkt_out;

    logic [INFL_W-1:0] inflight;

    logic [CNT_W-1:0] ch;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic             last_word;

    tag_t             issue_tag;
    tag_t             pipe [RD_LAT];
    tag_t             tag_r;
    logic [DATA_W-1:0] data_r;

    xbus_pkt_gen_cnt u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .advance   (issue),
        .ch_max    (ch_max_r),
        .col_max   (col_max_r),
        .row_max   (row_max_r),
        .ch        (ch),
        .col       (col),
        .row       (row),
        .last_word (last_word)
    );

    assign issue_tag = make_tag(last_word, row, col, ch);
    assign pkt_out   = pipe[RD_LAT-1].valid;

    // Next state: accept start, issue unless stalled, drain the read pipe.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        issue   = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (!full_r) begin
                    issue = 1'b1;
                    if (last_word) begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (inflight == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register; done is registered so it follows the last packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            done_r <= done_n;
        end
    end

    // Sweep limits are frozen for the whole sweep once start is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_max_r  <= '0;
            col_max_r <= '0;
            row_max_r <= '0;
        end else if (accept) begin
            ch_max_r  <= INC2_minus_1;
            col_max_r <= INW_ - 16'd1;
            row_max_r <= INH2 - 16'd1;
        end
    end

    // Read address walks linearly from base and wraps at 2^ADDR_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r <= '0;
        end else if (accept) begin
            addr_r <= base_addr;
        end else if (issue) begin
            addr_r <= addr_r + ADDR_W'(1);
        end
    end

    // One register stage on the OR of the cache-full flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r <= 1'b0;
        end else begin
            full_r <= |bus.cache_full;
        end
    end

    // Count reads issued but not yet emitted as packets.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            unique case ({issue, pkt_out})
                2'b10:   inflight <= inflight + INFL_W'(1);
                2'b01:   inflight <= inflight - INFL_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Tag delay line, aligned with the RAM read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= issue ? issue_tag : tag_t'('0);
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Output register; tag reads zero whenever no packet is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_r  <= '0;
            data_r <= '0;
        end else if (pkt_out) begin
            tag_r  <= pipe[RD_LAT-1];
            data_r <= bus.xbuf_rd_data;
        end else begin
            tag_r  <= '0;
        end
    end

    assign bus.xbuf_rd_en   = issue;
    assign bus.xbuf_rd_addr = addr_r;
    assign bus.pkt_tag      = tag_r;
    assign bus.pkt_data     = data_r;
    assign busy             = (state != IDLE);
    assign done             = done_r;

endmodule

// File: tb/tb_xbus_pkt_gen.sv
// Self-checking bench for xbus_pkt_gen: a sweep model predicts addresses
// and packets in order; directed scenarios pin timing and edge cases.
module tb_xbus_pkt_gen;
    import xbus_pkt_gen_pkg::*;

    localparam int RD_LAT = 2;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [15:0]       inc2_m1;
    logic [15:0]       inw;
    logic [15:0]       inh2;
    logic [ADDR_W-1:0] base;
    logic              busy;
    logic              done;

    xbus_pkt_gen_if #(.ADDR_W(ADDR_W)) bus ();

    xbus_pkt_gen #(
        .RD_LAT (RD_LAT),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .INC2_minus_1 (inc2_m1),
        .INW_         (inw),
        .INH2         (inh2),
        .base_addr    (base),
        .busy         (busy),
        .done         (done),
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM contents are a fixed function of the address.
    function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
        return {a, a ^ 16'hA5C3};
    endfunction

    logic [DATA_W-1:0] ram_pipe [RD_LAT];
    always @(posedge clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) ram_pipe[i] <= ram_pipe[i-1];
        ram_pipe[0] <= bus.xbuf_rd_en ? ram_word(bus.xbuf_rd_addr) : '0;
    end
    assign bus.xbuf_rd_data = ram_pipe[RD_LAT-1];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Sweep model: expected read addresses and packets in emission order.
    logic [ADDR_W-1:0]         exp_addr [$];
    logic [XBUS_TAG_WIDTH-1:0] exp_tag  [$];
    logic [DATA_W-1:0]         exp_data [$];

    task automatic model_sweep(input logic [ADDR_W-1:0] b, input int nch,
                               input int ncol, input int nrow);
        int idx = 0;
        logic [ADDR_W-1:0] a;
        logic last;
        for (int r = 0; r < nrow; r++)
            for (int c = 0; c < ncol; c++)
                for (int k = 0; k < nch; k++) begin
                    a = b + ADDR_W'(idx);
                    last = (r == nrow - 1) && (c == ncol - 1) && (k == nch - 1);
                    exp_addr.push_back(a);
                    exp_tag.push_back({1'b1, last, 16'(r), 16'(c), 16'(k)});
                    exp_data.push_back(ram_word(a));
                    idx++;
                end
    endtask

    logic [ADDR_W-1:0]         rd_log  [$];
    int                        rd_cyc  [$];
    logic [XBUS_TAG_WIDTH-1:0] tag_log [$];
    int                        pkt_cyc [$];

    task automatic clear_all();
        exp_addr.delete(); exp_tag.delete(); exp_data.delete();
        rd_log.delete(); rd_cyc.delete(); tag_log.delete(); pkt_cyc.delete();
    endtask

    logic mon_on = 1'b0;
    logic cf_prev = 1'b0;
    int   done_cnt = 0;
    int   last_pkt_cyc = -10;

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (mon_on) begin
            if (cf_prev) check("stall_rd_en", 64'(bus.xbuf_rd_en), 64'd0);
            if (bus.xbuf_rd_en) begin
                rd_log.push_back(bus.xbuf_rd_addr);
                rd_cyc.push_back(cyc);
                if (exp_addr.size() == 0) fail_now("rd_unexpected");
                else check("rd_addr", 64'(bus.xbuf_rd_addr), 64'(exp_addr.pop_front()));
            end
            if (bus.pkt_tag[TAG_VALID]) begin
                tag_log.push_back(bus.pkt_tag);
                pkt_cyc.push_back(cyc);
                last_pkt_cyc = cyc;
                if (exp_tag.size() == 0) fail_now("pkt_unexpected");
                else begin
                    check("pkt_tag", 64'(bus.pkt_tag), 64'(exp_tag.pop_front()));
                    check("pkt_data", 64'(bus.pkt_data), 64'(exp_data.pop_front()));
                end
            end else begin
                check("idle_tag", 64'(bus.pkt_tag), 64'd0);
            end
            if (done) begin
                check("done_after_last", 64'(cyc - last_pkt_cyc), 64'd1);
                check("done_all_pkts", 64'(exp_tag.size()), 64'd0);
                check("done_busy_low", 64'(busy), 64'd0);
            end
        end
        if (done) done_cnt++;
        cf_prev = |bus.cache_full;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [15:0] ch_m1,
                               input logic [15:0] w, input logic [15:0] h);
        base = b; inc2_m1 = ch_m1; inw = w; inh2 = h;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt > d0) return;
        end
        fail_now(name);
    endtask

    function automatic int count_in(input int q [$], input int lo, input int hi);
        int n = 0;
        foreach (q[i]) if (q[i] >= lo && q[i] <= hi) n++;
        return n;
    endfunction

    initial begin
        int d0;
        int k;
        int nlast;
        rst = 1'b1; start = 1'b0;
        inc2_m1 = '0; inw = '0; inh2 = '0; base = '0;
        bus.cache_full = '0;

        // Reset state
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_en", 64'(bus.xbuf_rd_en), 64'd0);
        check("rst_rd_addr", 64'(bus.xbuf_rd_addr), 64'd0);
        check("rst_pkt_tag", 64'(bus.pkt_tag), 64'd0);
        check("rst_pkt_data", 64'(bus.pkt_data), 64'd0);
        rst = 1'b0;
        tick();
        mon_on = 1'b1;

        // Single packet
        clear_all();
        d0 = done_cnt;
        model_sweep(16'h0010, 1, 1, 1);
        pulse_start(16'h0010, 16'd0, 16'd1, 16'd1);
        wait_done(40, "single_done_timeout");
        tick();
        check("single_rd_cnt", 64'(rd_log.size()), 64'd1);
        check("single_pkt_cnt", 64'(tag_log.size()), 64'd1);
        if (rd_log.size() > 0 && tag_log.size() > 0) begin
            check("single_addr", 64'(rd_log[0]), 64'h10);
            check("single_tag", 64'(tag_log[0]), 64'h3_0000_0000_0000);
            check("single_latency", 64'(pkt_cyc[0] - rd_cyc[0]), 64'd3);
        end
        check("single_done_cnt", 64'(done_cnt - d0), 64'd1);
        check("single_busy_after", 64'(busy), 64'd0);

        // Full sweep with an ignored second start
        clear_all();
        d0 = done_cnt;
        model_sweep(16'h0000, 2, 3, 2);
        pulse_start(16'h0000, 16'd1, 16'd3, 16'd2);
        repeat (3) tick();
        pulse_start(16'h0100, 16'd0, 16'd1, 16'd1);
        wait_done(100, "sweep_done_timeout");
        repeat (3) tick();
        check("sweep_rd_cnt", 64'(rd_log.size()), 64'd12);
        check("sweep_pkt_cnt", 64'(tag_log.size()), 64'd12);
        if (rd_log.size() == 12 && tag_log.size() == 12) begin
            check("sweep_addr0", 64'(rd_log[0]), 64'h0);
            check("sweep_addr11", 64'(rd_log[11]), 64'hb);
            check("sweep_tag1", 64'(tag_log[1]), 64'h2_0000_0000_0001);
            check("sweep_tag2", 64'(tag_log[2]), 64'h2_0000_0001_0000);
            check("sweep_tag11", 64'(tag_log[11]), 64'h3_0001_0002_0001);
        end
        nlast = 0;
        foreach (tag_log[i]) if (tag_log[i][TAG_LAST]) nlast++;
        check("sweep_one_last", 64'(nlast), 64'd1);
        check("sweep_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Backpressure from the top filter for 5 cycles
        clear_all();
        d0 = done_cnt;
        model_sweep(16'h0040, 2, 3, 2);
        pulse_start(16'h0040, 16'd1, 16'd3, 16'd2);
        repeat (4) tick();
        k = cyc;
        bus.cache_full = 4'b1000;
        repeat (5) tick();
        bus.cache_full = '0;
        wait_done(100, "bp_done_timeout");
        tick();
        check("bp_rd_before", 64'(count_in(rd_cyc, k, k)), 64'd1);
        check("bp_rd_stalled", 64'(count_in(rd_cyc, k + 1, k + 5)), 64'd0);
        check("bp_rd_resume", 64'(count_in(rd_cyc, k + 6, k + 6)), 64'd1);
        check("bp_pkts_bounded",
              64'(count_in(pkt_cyc, k + 1, k + 5) <= RD_LAT + 2), 64'd1);
        check("bp_pkt_cnt", 64'(tag_log.size()), 64'd12);
        check("bp_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Address wrap
        clear_all();
        model_sweep(16'hFFFE, 2, 2, 1);
        pulse_start(16'hFFFE, 16'd1, 16'd2, 16'd1);
        wait_done(40, "wrap_done_timeout");
        tick();
        check("wrap_rd_cnt", 64'(rd_log.size()), 64'd4);
        if (rd_log.size() == 4) begin
            check("wrap_addr0", 64'(rd_log[0]), 64'hFFFE);
            check("wrap_addr1", 64'(rd_log[1]), 64'hFFFF);
            check("wrap_addr2", 64'(rd_log[2]), 64'h0000);
            check("wrap_addr3", 64'(rd_log[3]), 64'h0001);
        end

        // Reset mid-sweep
        clear_all();
        model_sweep(16'h0000, 2, 3, 2);
        pulse_start(16'h0000, 16'd1, 16'd3, 16'd2);
        for (int i = 0; i < 50 && tag_log.size() < 5; i++) tick();
        if (tag_log.size() < 5) fail_now("midrst_pkt5_timeout");
        mon_on = 1'b0;
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_pkt_tag", 64'(bus.pkt_tag), 64'd0);
        check("midrst_rd_en", 64'(bus.xbuf_rd_en), 64'd0);
        repeat (10) tick();
        check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        clear_all();
        model_sweep(16'h0020, 2, 2, 1);
        mon_on = 1'b1;
        pulse_start(16'h0020, 16'd1, 16'd2, 16'd1);
        wait_done(40, "midrst_restart_timeout");
        tick();
        check("midrst_restart_pkts", 64'(tag_log.size()), 64'd4);
        check("midrst_restart_done", 64'(done_cnt - d0), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
